// File: rtl/seg_scan_driver.sv
// seg_scan_driver
// Multiplexed 7-segment display driver. The 1 kHz scan clock from the divider
// is synchronised and edge-detected in the clk domain. Each rising edge steps
// one digit, with an all-dark blank interval before the digit is lit. A shadow
// copy of the digit bus, decimal points and leading-zero enable is taken at the
// start of every frame, so a frame never mixes old and new values.
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-high reset
//   scan_in     divided scan clock (asynchronous to clk)
//   digits      packed digit values, digit i in [4i+3:4i]
//   dp_mask     decimal point per digit, 1 = lit
//   lzb_en      leading-zero blanking enable, captured with the snapshot
//   an          digit enables, active-low
//   seg         segments, active-low, {dp,g,f,e,d,c,b,a}
//   frame_start one-cycle pulse in the cycle the snapshot is taken
module seg_scan_driver #(
    parameter int DIGITS    = 8,
    parameter int BLANK_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scan_in,
    input  logic [4*DIGITS-1:0]   digits,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic                  lzb_en,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            seg,
    output logic                  frame_start
);

    localparam int              IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [7:0]      CNT_LAST = 8'(BLANK_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_SHOW
    } state_t;

    // Synchroniser and edge detector
    logic sync1_q, sync2_q, sync3_q;
    logic tick;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [4*DIGITS-1:0]   digits_sh_q, digits_sh_d;
    logic [DIGITS-1:0]     dp_sh_q, dp_sh_d;
    logic                  lzb_sh_q, lzb_sh_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic [7:0]            seg_q, seg_d;
    logic                  frame_start_q, frame_start_d;

    logic [3:0]            dig_sh [DIGITS];
    logic [DIGITS-1:0]     lead_zero;     // digit and everything above it is 0
    logic [DIGITS-1:0]     blank_digit;   // digit suppressed by leading-zero blanking
    logic [DIGITS-1:0]     an_show;       // active-low enable pattern for idx_d

    assign tick = sync2_q & ~sync3_q;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign dig_sh[gi]  = digits_sh_q[4*gi +: 4];
            assign an_show[gi] = (idx_d != IDX_W'(gi));
            // Leading-zero chain runs from the most significant digit down.
            if (gi == DIGITS - 1) begin : g_top
                assign lead_zero[gi] = (dig_sh[gi] == 4'h0);
            end else begin : g_rest
                assign lead_zero[gi] = (dig_sh[gi] == 4'h0) & lead_zero[gi+1];
            end
            // Digit 0 always shows, even when the whole value is zero.
            if (gi == 0) begin : g_lsd
                assign blank_digit[gi] = 1'b0;
            end else begin : g_upper
                assign blank_digit[gi] = lzb_sh_q & lead_zero[gi];
            end
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        digits_sh_d   = digits_sh_q;
        dp_sh_d       = dp_sh_q;
        lzb_sh_d      = lzb_sh_q;
        frame_start_d = 1'b0;

        case (state_q)
            ST_BLANK: begin
                // Ticks arriving here are dropped, not queued.
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_SHOW;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin // ST_IDLE and ST_SHOW accept ticks
                if (tick) begin
                    state_d = ST_BLANK;
                    cnt_d   = 8'd0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                    if (idx_d == '0) begin
                        digits_sh_d   = digits;
                        dp_sh_d       = dp_mask;
                        lzb_sh_d      = lzb_en;
                        frame_start_d = 1'b1;
                    end
                end
            end
        endcase

        // Outputs are registered from the next state, so they change on the
        // same edge as the state itself.
        an_d  = '1;
        seg_d = 8'hFF;
        if (state_d == ST_SHOW) begin
            an_d  = an_show;
            seg_d = {~dp_sh_q[idx_d],
                     blank_digit[idx_d] ? 7'h7F : seg_decode(dig_sh[idx_d])};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            sync3_q       <= 1'b0;
            state_q       <= ST_IDLE;
            idx_q         <= IDX_LAST;
            cnt_q         <= 8'd0;
            digits_sh_q   <= '0;
            dp_sh_q       <= '0;
            lzb_sh_q      <= 1'b0;
            an_q          <= '1;
            seg_q         <= 8'hFF;
            frame_start_q <= 1'b0;
        end else begin
            sync1_q       <= scan_in;
            sync2_q       <= sync1_q;
            sync3_q       <= sync2_q;
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            digits_sh_q   <= digits_sh_d;
            dp_sh_q       <= dp_sh_d;
            lzb_sh_q      <= lzb_sh_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Testbench for seg_scan_driver (DIGITS=8, BLANK_CYC=16). A reference model
// tracks the digit index and the per-frame snapshot and derives the expected
// enable/segment pattern from the decode table and plain arithmetic.
module tb_seg_scan_driver;

    localparam int DIGITS    = 8;
    localparam int BLANK_CYC = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                scan_in;
    logic [4*DIGITS-1:0] digits;
    logic [DIGITS-1:0]   dp_mask;
    logic                lzb_en;
    logic [DIGITS-1:0]   an;
    logic [7:0]          seg;
    logic                frame_start;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          m_idx;
    logic [31:0] m_digits;
    logic [7:0]  m_dp;
    logic        m_lzb;

    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg_scan_driver #(.DIGITS(DIGITS), .BLANK_CYC(BLANK_CYC)) dut (
        .clk         (clk),
        .rst         (rst),
        .scan_in     (scan_in),
        .digits      (digits),
        .dp_mask     (dp_mask),
        .lzb_en      (lzb_en),
        .an          (an),
        .seg         (seg),
        .frame_start (frame_start)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    // Expected segment pattern for digit k of the modelled snapshot.
    function automatic logic [7:0] exp_seg(input int k);
        int  val;
        bit  blank;
        val   = int'((m_digits >> (4*k)) & 32'hF);
        blank = m_lzb && (k > 0) && ((m_digits >> (4*k)) == 32'd0);
        return {~m_dp[k], blank ? 7'h7F : seg_tbl[val]};
    endfunction

    // One scan step: raise scan_in, check blank entry, blank length and the
    // lit digit. If inject is set, a second scan_in edge lands inside BLANK.
    task automatic do_step(input bit inject);
        bit         exp_fs;
        logic [7:0] exp_an;
        logic [7:0] exp_sg;
        m_idx  = (m_idx + 1) % DIGITS;
        exp_fs = (m_idx == 0);
        if (exp_fs) begin
            m_digits = digits;
            m_dp     = dp_mask;
            m_lzb    = lzb_en;
        end
        exp_an = ~(8'd1 << m_idx);
        exp_sg = exp_seg(m_idx);

        @(negedge clk);
        scan_in = 1'b1;
        repeat (3) sample();
        check("fs_at_entry", {31'd0, frame_start}, {31'd0, exp_fs});
        check("an_blank_entry", {24'd0, an}, 32'hFF);
        check("seg_blank_entry", {24'd0, seg}, 32'hFF);
        for (int c = 1; c < BLANK_CYC; c++) begin
            sample();
            if (c == 1) begin
                check("fs_one_cycle", {31'd0, frame_start}, 32'd0);
                scan_in = 1'b0;
            end
            if (inject && c == 5) scan_in = 1'b1;
            if (inject && c == 8) scan_in = 1'b0;
        end
        check("an_blank_last", {24'd0, an}, 32'hFF);
        sample();
        check($sformatf("an_d%0d", m_idx), {24'd0, an}, {24'd0, exp_an});
        check($sformatf("seg_d%0d", m_idx), {24'd0, seg}, {24'd0, exp_sg});
        repeat (4) sample();
        check("an_hold", {24'd0, an}, {24'd0, exp_an});
    endtask

    task automatic run_frame();
        for (int k = 0; k < DIGITS; k++) do_step(1'b0);
    endtask

    function automatic logic [31:0] rand_digits();
        logic [31:0] v;
        int          top;
        v   = $urandom;
        top = $urandom_range(0, 8);   // force leading zeros above nibble 'top'
        if (top < 8) v = v & ((32'd1 << (4*top)) - 32'd1);
        return v;
    endfunction

    initial begin
        rst     = 1'b1;
        scan_in = 1'b0;
        digits  = '0;
        dp_mask = '0;
        lzb_en  = 1'b0;
        m_idx    = DIGITS - 1;
        m_digits = '0;
        m_dp     = '0;
        m_lzb    = 1'b0;
        repeat (3) sample();
        check("rst_an", {24'd0, an}, 32'hFF);
        check("rst_seg", {24'd0, seg}, 32'hFF);
        check("rst_fs", {31'd0, frame_start}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) sample();
        check("idle_an", {24'd0, an}, 32'hFF);

        // Zero value, no blanking, then a known decode frame.
        run_frame();
        digits  = 32'h12345678;
        dp_mask = 8'h04;
        run_frame();

        // Leading-zero blanking cases.
        digits  = 32'h00000407;
        dp_mask = 8'h00;
        lzb_en  = 1'b1;
        run_frame();
        digits  = 32'h0;
        run_frame();

        // Tearing: inputs change after the digit-0 tick.
        digits  = 32'hA5C3E1F0;
        dp_mask = 8'h81;
        lzb_en  = 1'b0;
        do_step(1'b0);
        digits  = 32'h0000BEEF;
        dp_mask = 8'h10;
        lzb_en  = 1'b1;
        for (int k = 1; k < DIGITS; k++) do_step(1'b0);
        run_frame();

        // Scan edge inside BLANK is ignored.
        do_step(1'b0);
        do_step(1'b1);
        do_step(1'b0);
        do_step(1'b1);
        do_step(1'b0);
        do_step(1'b0);
        do_step(1'b0);
        do_step(1'b0);

        // Randomised frames with random mid-frame input changes.
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < DIGITS; k++) begin
                if ($urandom_range(0, 3) == 0 || k == 0) begin
                    digits  = rand_digits();
                    dp_mask = 8'($urandom);
                    lzb_en  = 1'($urandom);
                end
                do_step($urandom_range(0, 4) == 0);
            end
        end

        // Reset while digit 3 is lit.
        for (int k = 0; k < 4; k++) do_step(1'b0);
        check("pre_rst_an", {24'd0, an}, 32'hF7);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_an", {24'd0, an}, 32'hFF);
        check("async_rst_seg", {24'd0, seg}, 32'hFF);
        @(negedge clk);
        rst = 1'b0;
        m_idx = DIGITS - 1;
        digits  = 32'h00000009;
        dp_mask = 8'h01;
        lzb_en  = 1'b1;
        run_frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
